// File: rtl/button_event.sv
// Turns a debounced button level into registered single-cycle event pulses:
// press, release, click, double click, long press and auto-repeat.
module button_event #(
  parameter logic PRESS_LEVEL = 1'b0,
  parameter int   LONG_CYC    = 20,
  parameter int   REPEAT_CYC  = 8,
  parameter int   DBL_CYC     = 10,
  parameter int   CNT_W       = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dbl_click_o,
  output logic long_press_o,
  output logic repeat_o
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG, GAP} state_e;

  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_MAX  = CNT_W'(DBL_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             second_q, second_d;
  logic             s_q;
  logic             press_q, release_q, click_q, dbl_q, long_q, rep_q;
  logic             click_d, dbl_d, long_d, rep_d;
  logic             s, pe, re;

  assign s  = (in_i == PRESS_LEVEL);
  assign pe = s & ~s_q;
  assign re = ~s & s_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    second_d = second_q;
    click_d  = 1'b0;
    dbl_d    = 1'b0;
    long_d   = 1'b0;
    rep_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pe) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          second_d = 1'b0;
        end
      end
      PRESSED: begin
        // A release on the long-press edge wins: the press counts as short.
        if (re) begin
          state_d = second_q ? IDLE : GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_MAX) begin
          long_d  = 1'b1;
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (re) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REP_MAX) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        // A second press on the timeout edge still counts as a double click.
        if (pe) begin
          dbl_d    = 1'b1;
          state_d  = PRESSED;
          cnt_d    = '0;
          second_d = 1'b1;
        end else if (cnt_q == DBL_MAX) begin
          click_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      second_q  <= 1'b0;
      s_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      second_q  <= second_d;
      s_q       <= s;
      press_q   <= pe;
      release_q <= re;
      click_q   <= click_d;
      dbl_q     <= dbl_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign held_o       = s_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign click_o      = click_q;
  assign dbl_click_o  = dbl_q;
  assign long_press_o = long_q;
  assign repeat_o     = rep_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: expected pulses are queued with their
// edge number when stimulus is driven and compared every cycle.
module tb_button_event;

  localparam logic [5:0] EP = 6'b100000, ER = 6'b010000, EC = 6'b001000,
                         ED = 6'b000100, EL = 6'b000010, EK = 6'b000001;

  typedef struct {
    int         cyc;
    logic [5:0] mask;
  } evt_t;

  logic gclk, grst_n, in_i;
  logic held_o, press_o, release_o, click_o, dbl_click_o, long_press_o, repeat_o;

  int   cyc;
  int   n_chk, n_err;
  evt_t sb_q[$];

  button_event dut (
    .clk_i       (gclk),
    .rst_ni      (grst_n),
    .in_i        (in_i),
    .held_o      (held_o),
    .press_o     (press_o),
    .release_o   (release_o),
    .click_o     (click_o),
    .dbl_click_o (dbl_click_o),
    .long_press_o(long_press_o),
    .repeat_o    (repeat_o)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  initial cyc = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Insert in edge order, merging pulses expected on the same edge.
  task automatic push(input int c, input logic [5:0] m);
    int i;
    evt_t e;
    for (i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].cyc == c) begin
        sb_q[i].mask = sb_q[i].mask | m;
        return;
      end
      if (sb_q[i].cyc > c) break;
    end
    e.cyc  = c;
    e.mask = m;
    sb_q.insert(i, e);
  endtask

  always @(negedge gclk) begin
    logic [5:0] got, exp;
    got = {press_o, release_o, click_o, dbl_click_o, long_press_o, repeat_o};
    exp = '0;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      chk($sformatf("missed@%0d", sb_q[0].cyc), 32'(got), 32'(sb_q[0].mask));
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) exp = sb_q.pop_front().mask;
    chk($sformatf("evt@%0d", cyc), 32'(got), 32'(exp));
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge gclk);
  endtask

  // Called right after a negedge; returns the edge that samples the change.
  task automatic do_press(output int n);
    chk("held_before_press", 32'(held_o), 32'd0);
    in_i = 1'b0;
    n = cyc + 1;
    push(n, EP);
  endtask

  task automatic do_release(output int r);
    chk("held_before_release", 32'(held_o), 32'd1);
    in_i = 1'b1;
    r = cyc + 1;
    push(r, ER);
  endtask

  initial begin
    int n, r, r2, t;
    n_chk  = 0;
    n_err  = 0;
    in_i   = 1'b1;
    grst_n = 1'b0;
    wait_n(3);
    chk("reset_outs", 32'({held_o, press_o, release_o, click_o, dbl_click_o,
                           long_press_o, repeat_o}), 32'd0);
    grst_n = 1'b1;
    wait_n(3);

    // 1: async reset mid-LONG, then restart with the button still pressed
    do_press(n);
    push(n + 20, EL);
    wait_n(25);
    #2 grst_n = 1'b0;
    sb_q.delete();
    #1 chk("async_rst_outs", 32'({held_o, press_o, release_o, click_o, dbl_click_o,
                                  long_press_o, repeat_o}), 32'd0);
    wait_n(3);
    grst_n = 1'b1;
    n = cyc + 1;
    push(n, EP);
    push(n + 20, EL);
    wait_n(22);
    do_release(r);
    wait_n(15);

    // 2: short click
    do_press(n);
    wait_n(5);
    do_release(r);
    push(r + 10, EC);
    wait_n(15);

    // 3: double click, second press released short -> no click
    do_press(n);
    wait_n(5);
    do_release(r);
    wait_n(4);
    do_press(n);
    push(n, ED);
    wait_n(3);
    do_release(r2);
    wait_n(15);

    // 4a: second press exactly on the timeout edge
    do_press(n);
    wait_n(5);
    do_release(r);
    wait_n(10);
    do_press(n);
    push(n, ED);
    wait_n(3);
    do_release(r2);
    wait_n(15);

    // 4b: one edge too late -> click then a fresh press
    do_press(n);
    wait_n(5);
    do_release(r);
    push(r + 10, EC);
    wait_n(11);
    do_press(n);
    wait_n(3);
    do_release(r2);
    push(r2 + 10, EC);
    wait_n(15);

    // 5: long press with repeats, release gives no click
    do_press(n);
    push(n + 20, EL);
    push(n + 28, EK);
    push(n + 36, EK);
    push(n + 44, EK);
    wait_n(50);
    do_release(r);
    wait_n(15);

    // 6: release on the long-press edge wins
    do_press(n);
    wait_n(20);
    do_release(r);
    push(n + 30, EC);
    wait_n(5);

    t = 0;
    while (sb_q.size() > 0 && t < 200) begin
      wait_n(1);
      t++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    wait_n(5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
